// File: rtl/intarb_pkg.sv
// Shared types and constants for the interrupt arbiter: WFI state encoding,
// standard interrupt codes and their fixed priority order.
package intarb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    WAKE,
    TOUT
  } wfi_state_t;

  localparam int unsigned MEI = 11;
  localparam int unsigned MSI = 3;
  localparam int unsigned MTI = 7;
  localparam int unsigned SEI = 9;
  localparam int unsigned SSI = 1;
  localparam int unsigned STI = 5;

  // Highest priority first; indices >= FIRST_LOCAL_INT follow in ascending order.
  localparam int unsigned NUM_STD_PRIO = 6;
  localparam int unsigned STD_PRIO [NUM_STD_PRIO] = '{MEI, MSI, MTI, SEI, SSI, STI};
  localparam int unsigned FIRST_LOCAL_INT = 12;

  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_S = 2'd1;
  localparam logic [1:0] PRIV_M = 2'd3;

endpackage

// File: rtl/intarb_intprio.sv
// Combinational fixed-priority selector: standard interrupts first, then
// local interrupts in ascending index; reserved low bits never win.
module intprio import intarb_pkg::*; #(
  parameter int unsigned NUM_INT  = 16,
  parameter int unsigned IDX_BITS = 6
) (
  input  logic [NUM_INT-1:0]  req,
  output logic                valid,
  output logic [IDX_BITS-1:0] idx
);

  logic unusedReserved;
  assign unusedReserved = ^{req[0], req[2], req[4], req[6], req[8], req[10]};

  // Later assignments override earlier ones, so scan from lowest to highest priority.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = NUM_INT - 1; i >= int'(FIRST_LOCAL_INT); i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = IDX_BITS'(i);
      end
    end
    for (int k = NUM_STD_PRIO - 1; k >= 0; k--) begin
      if (req[STD_PRIO[k]]) begin
        valid = 1'b1;
        idx   = IDX_BITS'(STD_PRIO[k]);
      end
    end
  end

endmodule

// File: rtl/intarb.sv
// Interrupt arbiter with M/S delegation, registered selection (SelR) and a
// WFI sequencer with programmable timeout fault.
module intarb import intarb_pkg::*; #(
  parameter int unsigned NUM_INT      = 16,
  parameter int unsigned CAUSE_BITS   = 6,
  parameter int unsigned WFI_CNT_BITS = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_INT-1:0]      MIP_REGW,
  input  logic [NUM_INT-1:0]      MIE_REGW,
  input  logic [NUM_INT-1:0]      MIDELEG_REGW,
  input  logic                    STATUS_MIE,
  input  logic                    STATUS_SIE,
  input  logic                    STATUS_TW,
  input  logic [1:0]              PrivilegeModeW,
  input  logic                    InstrValidM,
  input  logic                    CommittedM,
  input  logic                    CommittedF,
  input  logic                    wfiM,
  input  logic                    StallW,
  input  logic [WFI_CNT_BITS-1:0] WfiLimit,
  output logic                    InterruptM,
  output logic [CAUSE_BITS-1:0]   IntCauseM,
  output logic                    IntDelegateM,
  output logic                    IntPendingM,
  output logic                    WfiStallM,
  output logic                    WfiTimeoutFaultM
);

  logic [NUM_INT-1:0]    pendEn, mElig, sElig;
  logic                  mEnable, sEnable;
  logic                  mValid, sValid;
  logic [CAUSE_BITS-1:0] mIdx, sIdx;
  logic                  selValid, selDeleg;
  logic [CAUSE_BITS-1:0] selCause;

  logic                    SelRValid, SelRDeleg;
  logic [CAUSE_BITS-1:0]   SelRCause;
  wfi_state_t              state;
  logic [WFI_CNT_BITS-1:0] wfiCnt;

  assign pendEn  = MIP_REGW & MIE_REGW;
  assign mEnable = (PrivilegeModeW != PRIV_M) | STATUS_MIE;
  // S-level interrupts are masked outright in M mode.
  assign sEnable = (PrivilegeModeW == PRIV_U) | ((PrivilegeModeW == PRIV_S) & STATUS_SIE);
  assign mElig   = pendEn & ~MIDELEG_REGW & {NUM_INT{mEnable}};
  assign sElig   = pendEn & MIDELEG_REGW & {NUM_INT{sEnable}};

  intprio #(
    .NUM_INT (NUM_INT),
    .IDX_BITS(CAUSE_BITS)
  ) u_mPrio (
    .req  (mElig),
    .valid(mValid),
    .idx  (mIdx)
  );

  intprio #(
    .NUM_INT (NUM_INT),
    .IDX_BITS(CAUSE_BITS)
  ) u_sPrio (
    .req  (sElig),
    .valid(sValid),
    .idx  (sIdx)
  );

  always_comb begin
    selValid = mValid | sValid;
    selDeleg = 1'b0;
    selCause = '0;
    if (mValid) begin
      selCause = mIdx;
    end else if (sValid) begin
      selCause = sIdx;
      selDeleg = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      SelRValid   <= 1'b0;
      SelRDeleg   <= 1'b0;
      SelRCause   <= '0;
      IntPendingM <= 1'b0;
    end else begin
      SelRValid   <= selValid;
      SelRDeleg   <= selDeleg;
      SelRCause   <= selCause;
      IntPendingM <= |pendEn;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      wfiCnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (wfiM & InstrValidM & ~StallW) begin
            state  <= WAIT;
            wfiCnt <= '0;
          end
        end
        WAIT: begin
          if (wfiCnt != '1) wfiCnt <= wfiCnt + 1'b1;
          // A pending interrupt wins over a simultaneous timeout.
          if (IntPendingM) begin
            state <= WAKE;
          end else if (STATUS_TW & (PrivilegeModeW != PRIV_M) & (wfiCnt == WfiLimit)) begin
            state <= TOUT;
          end
        end
        WAKE:    state <= IDLE;
        TOUT:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign InterruptM       = SelRValid & ~CommittedM & ~CommittedF &
                            (InstrValidM | (state == WAKE));
  assign IntCauseM        = SelRCause;
  assign IntDelegateM     = SelRDeleg;
  assign WfiStallM        = (state == WAIT);
  assign WfiTimeoutFaultM = (state == TOUT);

endmodule

// File: tb/tb_intarb.sv
// Bench for intarb: directed scenarios then randomized traffic, all checked
// against a cycle-level behavioural model of the arbiter and WFI sequencer.
module tb_intarb;

  localparam int unsigned N   = 16;
  localparam int unsigned CB  = 6;
  localparam int unsigned W   = 16;
  localparam int CNT_MAX      = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  mip, mie, mideleg;
  logic          sMie, sSie, sTw;
  logic [1:0]    mode;
  logic          iv, cm, cf, wfi, stallW;
  logic [W-1:0]  limit;
  logic          InterruptM, IntDelegateM, IntPendingM, WfiStallM, WfiTimeoutFaultM;
  logic [CB-1:0] IntCauseM;

  int nCmp = 0;
  int nErr = 0;

  // Model state: 0 idle, 1 waiting, 2 waking, 3 timed out.
  bit mSelV, mSelD, mPend;
  int mSelC, mState, mCnt;
  int order[$];

  always #5 clk = ~clk;

  intarb #(
    .NUM_INT     (N),
    .CAUSE_BITS  (CB),
    .WFI_CNT_BITS(W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .MIP_REGW        (mip),
    .MIE_REGW        (mie),
    .MIDELEG_REGW    (mideleg),
    .STATUS_MIE      (sMie),
    .STATUS_SIE      (sSie),
    .STATUS_TW       (sTw),
    .PrivilegeModeW  (mode),
    .InstrValidM     (iv),
    .CommittedM      (cm),
    .CommittedF      (cf),
    .wfiM            (wfi),
    .StallW          (stallW),
    .WfiLimit        (limit),
    .InterruptM      (InterruptM),
    .IntCauseM       (IntCauseM),
    .IntDelegateM    (IntDelegateM),
    .IntPendingM     (IntPendingM),
    .WfiStallM       (WfiStallM),
    .WfiTimeoutFaultM(WfiTimeoutFaultM)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(logic [N-1:0] v);
    foreach (order[k]) if (v[order[k]]) return order[k];
    return -1;
  endfunction

  task automatic modelEdge();
    logic [N-1:0] pe, mE, sE;
    bit mOn, sOn;
    int mc, sc;
    pe  = mip & mie;
    mOn = (mode != 2'd3) || sMie;
    sOn = (mode == 2'd0) || (mode == 2'd1 && sSie);
    mE  = mOn ? (pe & ~mideleg) : '0;
    sE  = sOn ? (pe & mideleg) : '0;
    if (!reset) begin
      mSelV = 0; mSelD = 0; mSelC = 0; mPend = 0; mState = 0; mCnt = 0;
      return;
    end
    case (mState)
      0: if (wfi && iv && !stallW) begin mState = 1; mCnt = 0; end
      1: begin
        if (mPend) mState = 2;
        else if (sTw && mode != 2'd3 && mCnt == int'(limit)) mState = 3;
        if (mCnt < CNT_MAX) mCnt++;
      end
      default: mState = 0;
    endcase
    mc = pick(mE);
    sc = pick(sE);
    if (mc >= 0) begin mSelV = 1; mSelD = 0; mSelC = mc; end
    else if (sc >= 0) begin mSelV = 1; mSelD = 1; mSelC = sc; end
    else begin mSelV = 0; mSelD = 0; mSelC = 0; end
    mPend = |pe;
  endtask

  task automatic checkAll();
    bit expInt;
    expInt = mSelV && !cm && !cf && (iv || mState == 2);
    check("InterruptM", 64'(InterruptM), 64'(expInt));
    check("IntCauseM", 64'(IntCauseM), 64'(mSelC));
    check("IntDelegateM", 64'(IntDelegateM), 64'(mSelD));
    check("IntPendingM", 64'(IntPendingM), 64'(mPend));
    check("WfiStallM", 64'(WfiStallM), 64'(mState == 1));
    check("WfiTimeoutFaultM", 64'(WfiTimeoutFaultM), 64'(mState == 3));
  endtask

  // Check outputs for the current inputs, then advance one clock.
  task automatic step();
    #1;
    checkAll();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic quiet();
    mip = '0; mie = '0; mideleg = '0; sMie = 0; sSie = 0; sTw = 0; mode = 2'd0;
    iv = 0; cm = 0; cf = 0; wfi = 0; stallW = 0; limit = '0;
  endtask

  initial begin
    int nStall;
    bit seenFault;
    order = '{11, 3, 7, 9, 1, 5};
    for (int i = 12; i < int'(N); i++) order.push_back(i);

    quiet();
    reset = 0;
    @(posedge clk);
    modelEdge();
    #1;
    step();
    check("reset InterruptM", 64'(InterruptM), 0);
    check("reset WfiStallM", 64'(WfiStallM), 0);
    reset = 1;

    // Standard priority: MEI over MTI.
    mip = 16'h0880; mie = 16'h0880; iv = 1;
    step();
    check("tp1 InterruptM", 64'(InterruptM), 1);
    check("tp1 cause", 64'(IntCauseM), 11);
    check("tp1 delegate", 64'(IntDelegateM), 0);
    cm = 1;
    step();
    check("committed suppress", 64'(InterruptM), 0);
    cm = 0;

    // M-level local interrupt beats a delegated SSI.
    mip = 16'h1002; mie = 16'h1002; mideleg = 16'h0002; mode = 2'd1; sSie = 1;
    step();
    check("tp2 cause", 64'(IntCauseM), 12);
    check("tp2 delegate", 64'(IntDelegateM), 0);
    mip = 16'h0002;
    step();
    check("tp2b cause", 64'(IntCauseM), 1);
    check("tp2b delegate", 64'(IntDelegateM), 1);
    check("tp2b InterruptM", 64'(InterruptM), 1);

    // M mode with MIE clear: pending but not taken.
    quiet(); iv = 1; mode = 2'd3; mip = 16'h0080; mie = 16'h0080;
    step();
    check("tp3 pending", 64'(IntPendingM), 1);
    check("tp3 InterruptM", 64'(InterruptM), 0);

    // Timeout with limit 4: five stall cycles then one fault pulse.
    quiet(); step();
    sTw = 1; limit = 4; iv = 1; wfi = 1;
    step();
    wfi = 0; iv = 0;
    nStall = 0;
    seenFault = 0;
    for (int k = 0; k < 20 && !seenFault; k++) begin
      if (WfiStallM) nStall++;
      if (WfiTimeoutFaultM) seenFault = 1;
      else step();
    end
    check("tout stall cycles", 64'(nStall), 5);
    check("tout fault seen", 64'(seenFault), 1);
    step();
    check("tout single pulse", 64'(WfiTimeoutFaultM), 0);

    // Interrupt pending exactly when the timeout would fire: wake wins.
    limit = 3; iv = 1; wfi = 1;
    step();
    wfi = 0; iv = 0;
    step();
    step();
    mip = 16'h0080; mie = 16'h0080;
    step();
    step();
    check("race stall", 64'(WfiStallM), 0);
    check("race fault", 64'(WfiTimeoutFaultM), 0);
    check("race InterruptM", 64'(InterruptM), 1);
    step();
    mip = '0; mie = '0;
    step();

    // Reset during WAIT, then a fresh WFI times out at limit 1 from count 0.
    iv = 1; wfi = 1; limit = 1;
    step();
    wfi = 0; iv = 0;
    step();
    step();
    reset = 0;
    step();
    check("wait reset stall", 64'(WfiStallM), 0);
    check("wait reset fault", 64'(WfiTimeoutFaultM), 0);
    check("wait reset pending", 64'(IntPendingM), 0);
    reset = 1; iv = 1; wfi = 1;
    step();
    wfi = 0; iv = 0;
    check("restart stall0", 64'(WfiStallM), 1);
    step();
    check("restart stall1", 64'(WfiStallM), 1);
    step();
    check("restart fault", 64'(WfiTimeoutFaultM), 1);

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      reset   = ($urandom_range(0, 49) != 0);
      mip     = ($urandom_range(0, 9) < 3) ? N'($urandom) : '0;
      mie     = N'($urandom);
      mideleg = N'($urandom);
      sMie    = 1'($urandom);
      sSie    = 1'($urandom);
      sTw     = ($urandom_range(0, 9) < 7);
      mode    = 2'($urandom);
      iv      = 1'($urandom);
      cm      = ($urandom_range(0, 7) == 0);
      cf      = ($urandom_range(0, 7) == 0);
      wfi     = ($urandom_range(0, 5) == 0);
      stallW  = ($urandom_range(0, 5) == 0);
      limit   = W'($urandom_range(0, 6));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
